fpu_ss_prd_table: RTL and testbench
===================================

# fpu_ss_prd_table

Runtime-programmable, pipelined instruction predecoder for the FPU subsystem. It classifies each offered 32-bit instruction against a table of (data, mask, response) entries and returns the offload response: accept, writeback, memory-op flag and rs usage. The table resets to a parameter-supplied default, such as the Zfinx set, and software/debug logic can rewrite or disable individual entries. It sits between the core's offload request interface and the FPU decoder, with a one-stage registered output, valid/ready handshakes and a saturating miss counter.

## Interface
- NumEntries, 30: table depth, legal range 1..64; IdxW = max(1, $clog2(NumEntries)).
- DefaultTable, fpu_ss_pkg::offload_instr_t [NumEntries]: reset contents (instr_data, instr_mask, prd_rsp).
- MissCntW, 16: width of the miss counter.
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- in_valid_i  in  1  lookup request valid.
- in_ready_o  out  1  lookup request accepted when high together with in_valid_i.
- in_instr_i  in  32  instruction word.
- in_id_i  in  4  request tag, returned unchanged.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  result consumed.
- out_rsp_o  out  prd_rsp_t  {p_accept, p_writeback, p_is_mem_op, p_use_rs[2:0]}.
- out_hit_o  out  1  an enabled entry matched.
- out_idx_o  out  IdxW  index of the matching entry; 0 on miss.
- out_id_o  out  4  tag of the result.
- cfg_we_i  in  1  write one table entry.
- cfg_idx_i  in  IdxW  entry index to write.
- cfg_entry_i  in  offload_instr_t  new data, mask and response.
- cfg_en_i  in  1  new enable bit for the entry.
- miss_cnt_o  out  MissCntW  saturating count of completed misses.
- miss_clr_i  in  1  synchronous clear of the miss counter.

## Operation
- State: entry[NumEntries], en[NumEntries], an output register (valid, rsp, hit, idx, id) and miss_cnt.
- Match: entry i matches when en[i] is set and (in_instr_i & instr_mask[i]) == instr_data[i]. The lowest matching index wins (priority encoder).
- Hit: out_rsp_o is the entry's prd_rsp, out_hit_o=1 and out_idx_o=i.
- Miss: out_rsp_o is all zero (p_accept=0, p_use_rs=3'b000), out_hit_o=0 and out_idx_o=0.
- Accept and register: a lookup is accepted on in_valid_i && in_ready_o. On acceptance, the match result and in_id_i are registered into the output stage.
- in_ready_o = !out_valid_o || out_ready_i. This is a single-entry pipeline; back-to-back throughput is one lookup per cycle.
- Output hold: while out_valid_o && !out_ready_i, all out_* signals hold their values stably.
- Config write: on cfg_we_i with cfg_idx_i < NumEntries, entry[cfg_idx_i] and en[cfg_idx_i] are updated at the clock edge. A write with cfg_idx_i >= NumEntries is ignored.
- Write during lookup: a lookup accepted in the same cycle as a cfg write uses the pre-write table. The new contents affect lookups accepted from the next cycle on.
- Miss counting: miss_cnt increments when a result with out_hit_o=0 is transferred (out_valid_o && out_ready_i). It saturates at all-ones.
- Miss clear: miss_clr_i takes priority over the increment in the same cycle; the counter becomes 0.

## Timing
- Reset values:
  - out_valid_o=0, out_rsp_o=0, out_hit_o=0, out_idx_o=0, out_id_o=0.
  - miss_cnt_o=0.
  - entry[i]=DefaultTable[i], en[i]=1 for all i.
  - in_ready_o=1 once reset is released.
- Latency: 1 cycle. A request accepted at edge N has its result visible after edge N, with out_valid_o high in cycle N+1.
- Reset asserted mid-operation: the pending result is dropped immediately (asynchronous) and the table returns to the default contents.
- Decode path: combinational from in_instr_i to the output-register D inputs only. No combinational path from in_* to out_*.
- Ready path: the only combinational input-to-output path is out_ready_i -> in_ready_o.

## Test plan
- Default hit, FADD.S: after reset, in_instr_i=0x00B50553 (fadd.s x10,x10,x11) -> one cycle later out_hit_o=1, out_idx_o=4, p_accept=1, p_writeback=1, p_use_rs=3'b011, out_id_o equals in_id_i.
- Fused multiply-add and miss: 0x00000043 -> idx 0, p_use_rs=3'b111. Then 0x00000013 (addi) -> out_hit_o=0, p_accept=0, miss_cnt_o=1 after the transfer.
- Backpressure: hold out_ready_i=0 for 3 cycles while two requests are offered -> the first result stays stable, in_ready_o=0, the second request is not accepted. Releasing out_ready_i yields both results in order with the correct tags.
- Disable and write collision: in the same cycle, accept a lookup of 0x00B50553 and write cfg_idx_i=4 with cfg_en_i=0.
  - Expected: that lookup still hits idx 4.
  - The next 0x00B50553 misses and miss_cnt_o increments.
  - A write with cfg_idx_i=NumEntries leaves the table unchanged.
- Priority: program entry 2 with FADD.S data/mask and p_writeback=0 -> 0x00B50553 returns idx 2 and p_writeback=0. Re-enabling entry 4 does not change this result.
- Counter saturation: with MissCntW=2, issue 5 misses -> miss_cnt_o=3. Assert miss_clr_i in the same cycle as a miss transfer -> miss_cnt_o=0. Assert rst_i mid-stream -> out_valid_o drops immediately and the default table is restored.

Source files
------------

// File: rtl/fpu_ss_pkg.sv
// Shared types for the FPU subsystem predecoder and its default Zfinx table.
package fpu_ss_pkg;

  typedef struct packed {
    logic       p_accept;
    logic       p_writeback;
    logic       p_is_mem_op;
    logic [2:0] p_use_rs;
  } prd_rsp_t;

  typedef struct packed {
    logic [31:0] instr_data;
    logic [31:0] instr_mask;
    prd_rsp_t    prd_rsp;
  } offload_instr_t;

  localparam int unsigned PrdRspW       = $bits(prd_rsp_t);
  localparam int unsigned OffloadInstrW = $bits(offload_instr_t);

  // Instruction field masks used by the default table.
  localparam logic [31:0] MaskR4   = 32'h0600_007F;  // opcode + fmt, rs3/rm free
  localparam logic [31:0] MaskR    = 32'hFE00_007F;  // funct7 + opcode, rm free
  localparam logic [31:0] MaskRF3  = 32'hFE00_707F;  // funct7 + funct3 + opcode
  localparam logic [31:0] MaskR1   = 32'hFFF0_007F;  // funct7 + rs2 + opcode, rm free
  localparam logic [31:0] MaskR1F3 = 32'hFFF0_707F;  // funct7 + rs2 + funct3 + opcode

  // Zfinx ops all go through the integer register file, so none is a memory op
  // and every one of them writes a result back.
  function automatic offload_instr_t zfinx_entry(logic [31:0] data, logic [31:0] mask,
                                                 logic [2:0] use_rs);
    offload_instr_t e;
    e.instr_data          = data;
    e.instr_mask          = mask;
    e.prd_rsp.p_accept    = 1'b1;
    e.prd_rsp.p_writeback = 1'b1;
    e.prd_rsp.p_is_mem_op = 1'b0;
    e.prd_rsp.p_use_rs    = use_rs;
    return e;
  endfunction

  localparam int unsigned ZfinxNumEntries = 30;

  localparam offload_instr_t ZfinxTable [ZfinxNumEntries] = '{
    zfinx_entry(32'h0000_0043, MaskR4,   3'b111),  //  0 fmadd.s
    zfinx_entry(32'h0000_0047, MaskR4,   3'b111),  //  1 fmsub.s
    zfinx_entry(32'h0000_004B, MaskR4,   3'b111),  //  2 fnmsub.s
    zfinx_entry(32'h0000_004F, MaskR4,   3'b111),  //  3 fnmadd.s
    zfinx_entry(32'h0000_0053, MaskR,    3'b011),  //  4 fadd.s
    zfinx_entry(32'h0800_0053, MaskR,    3'b011),  //  5 fsub.s
    zfinx_entry(32'h1000_0053, MaskR,    3'b011),  //  6 fmul.s
    zfinx_entry(32'h1800_0053, MaskR,    3'b011),  //  7 fdiv.s
    zfinx_entry(32'h5800_0053, MaskR1,   3'b001),  //  8 fsqrt.s
    zfinx_entry(32'h2000_0053, MaskRF3,  3'b011),  //  9 fsgnj.s
    zfinx_entry(32'h2000_1053, MaskRF3,  3'b011),  // 10 fsgnjn.s
    zfinx_entry(32'h2000_2053, MaskRF3,  3'b011),  // 11 fsgnjx.s
    zfinx_entry(32'h2800_0053, MaskRF3,  3'b011),  // 12 fmin.s
    zfinx_entry(32'h2800_1053, MaskRF3,  3'b011),  // 13 fmax.s
    zfinx_entry(32'hC000_0053, MaskR1,   3'b001),  // 14 fcvt.w.s
    zfinx_entry(32'hC010_0053, MaskR1,   3'b001),  // 15 fcvt.wu.s
    zfinx_entry(32'hA000_2053, MaskRF3,  3'b011),  // 16 feq.s
    zfinx_entry(32'hA000_1053, MaskRF3,  3'b011),  // 17 flt.s
    zfinx_entry(32'hA000_0053, MaskRF3,  3'b011),  // 18 fle.s
    zfinx_entry(32'hE000_1053, MaskR1F3, 3'b001),  // 19 fclass.s
    zfinx_entry(32'hD000_0053, MaskR1,   3'b001),  // 20 fcvt.s.w
    zfinx_entry(32'hD010_0053, MaskR1,   3'b001),  // 21 fcvt.s.wu
    zfinx_entry(32'h0200_0053, MaskR,    3'b011),  // 22 fadd.d
    zfinx_entry(32'h0A00_0053, MaskR,    3'b011),  // 23 fsub.d
    zfinx_entry(32'h1200_0053, MaskR,    3'b011),  // 24 fmul.d
    zfinx_entry(32'h1A00_0053, MaskR,    3'b011),  // 25 fdiv.d
    zfinx_entry(32'h5A00_0053, MaskR1,   3'b001),  // 26 fsqrt.d
    zfinx_entry(32'h4010_0053, MaskR1,   3'b001),  // 27 fcvt.s.d
    zfinx_entry(32'h4200_0053, MaskR1,   3'b001),  // 28 fcvt.d.s
    zfinx_entry(32'hA200_2053, MaskRF3,  3'b011)   // 29 feq.d
  };

endpackage

// File: rtl/fpu_ss_prd_table.sv
// Runtime-programmable offload predecoder: matches each instruction against a
// (data, mask, response) table and returns the first enabled hit through a
// single registered output stage with valid/ready flow control.
module fpu_ss_prd_table #(
  parameter int unsigned                NumEntries = 30,
  parameter fpu_ss_pkg::offload_instr_t DefaultTable [NumEntries] = fpu_ss_pkg::ZfinxTable,
  parameter int unsigned                MissCntW = 16,
  localparam int unsigned               IdxW = (NumEntries > 1) ? $clog2(NumEntries) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  // Lookup request
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [31:0]                          in_instr_i,
  input  logic [3:0]                           in_id_i,
  // Lookup result
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [fpu_ss_pkg::PrdRspW-1:0]       out_rsp_o,
  output logic                                 out_hit_o,
  output logic [IdxW-1:0]                      out_idx_o,
  output logic [3:0]                           out_id_o,
  // Table programming
  input  logic                                 cfg_we_i,
  input  logic [IdxW-1:0]                      cfg_idx_i,
  input  logic [fpu_ss_pkg::OffloadInstrW-1:0] cfg_entry_i,
  input  logic                                 cfg_en_i,
  // Miss statistics
  output logic [MissCntW-1:0]                  miss_cnt_o,
  input  logic                                 miss_clr_i
);

  import fpu_ss_pkg::*;

  offload_instr_t          entry_q [NumEntries];
  logic [NumEntries-1:0]   en_q;
  offload_instr_t          cfg_entry;
  logic                    cfg_wr_ok;

  logic [NumEntries-1:0]   match;
  logic                    hit_d;
  logic [IdxW-1:0]         idx_d;
  prd_rsp_t                rsp_d;

  logic                    out_valid_q;
  prd_rsp_t                out_rsp_q;
  logic                    out_hit_q;
  logic [IdxW-1:0]         out_idx_q;
  logic [3:0]              out_id_q;
  logic                    accept;
  logic                    xfer_miss;

  logic [MissCntW-1:0]     miss_cnt_q;

  assign cfg_entry = offload_instr_t'(cfg_entry_i);
  // Indices past the table end are silently dropped.
  assign cfg_wr_ok = cfg_we_i && (32'(cfg_idx_i) < NumEntries);

  // Table storage: reset loads the default set, cfg writes update one entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NumEntries); i++) begin
        entry_q[i] <= DefaultTable[i];
      end
      en_q <= '1;
    end else if (cfg_wr_ok) begin
      entry_q[cfg_idx_i] <= cfg_entry;
      en_q[cfg_idx_i]    <= cfg_en_i;
    end
  end

  // Per-entry masked compare against the current (pre-write) table contents.
  always_comb begin
    match = '0;
    for (int i = 0; i < int'(NumEntries); i++) begin
      match[i] = en_q[i] && ((in_instr_i & entry_q[i].instr_mask) == entry_q[i].instr_data);
    end
  end

  // Priority encode: scan downwards so the lowest matching index wins.
  always_comb begin
    hit_d = 1'b0;
    idx_d = '0;
    rsp_d = '0;
    for (int i = int'(NumEntries) - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit_d = 1'b1;
        idx_d = IdxW'(i);
        rsp_d = entry_q[i].prd_rsp;
      end
    end
  end

  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;

  // Output stage: capture on accept, drop valid once consumed, else hold.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_rsp_q   <= '0;
      out_hit_q   <= 1'b0;
      out_idx_q   <= '0;
      out_id_q    <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_rsp_q   <= rsp_d;
      out_hit_q   <= hit_d;
      out_idx_q   <= idx_d;
      out_id_q    <= in_id_i;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_rsp_o   = out_rsp_q;
  assign out_hit_o   = out_hit_q;
  assign out_idx_o   = out_idx_q;
  assign out_id_o    = out_id_q;

  assign xfer_miss = out_valid_q && out_ready_i && !out_hit_q;

  // Miss counter: clear wins over increment, increment saturates at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      miss_cnt_q <= '0;
    end else if (miss_clr_i) begin
      miss_cnt_q <= '0;
    end else if (xfer_miss && (miss_cnt_q != '1)) begin
      miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_fpu_ss_prd_table.sv
// Scoreboard bench for fpu_ss_prd_table: a table-lookup reference model feeds an
// expected-result queue, a negedge monitor checks every presented result.
module tb_fpu_ss_prd_table;
  import fpu_ss_pkg::*;

  localparam int unsigned N    = 30;
  localparam int unsigned IdxW = 5;
  localparam int unsigned RW   = PrdRspW;
  localparam int unsigned EW   = OffloadInstrW;

  localparam logic [31:0]   FADD     = 32'h00B5_0553;
  localparam logic [31:0]   FMADD    = 32'h0000_0043;
  localparam logic [31:0]   FNMSUB   = 32'h0000_004B;
  localparam logic [31:0]   ADDI     = 32'h0000_0013;
  localparam logic [RW-1:0] RSP_FADD = 6'b110_011;
  localparam logic [RW-1:0] RSP_FMA  = 6'b110_111;
  localparam logic [RW-1:0] RSP_NOWB = 6'b100_011;

  typedef struct packed {
    logic            hit;
    logic [IdxW-1:0] idx;
    logic [RW-1:0]   rsp;
    logic [3:0]      id;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [31:0]     in_instr = '0;
  logic [3:0]      in_id = '0;
  logic            out_ready = 1'b1;
  logic            cfg_we = 1'b0;
  logic [IdxW-1:0] cfg_idx = '0;
  logic [EW-1:0]   cfg_entry = '0;
  logic            cfg_en = 1'b0;
  logic            miss_clr = 1'b0;

  logic            in_ready, out_valid, out_hit;
  logic [RW-1:0]   out_rsp;
  logic [IdxW-1:0] out_idx;
  logic [3:0]      out_id;
  logic [15:0]     miss_cnt;

  logic            s_in_ready, s_out_valid, s_out_hit;
  logic [RW-1:0]   s_out_rsp;
  logic [IdxW-1:0] s_out_idx;
  logic [3:0]      s_out_id;
  logic [1:0]      s_miss_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t        sb[$];
  logic [31:0] m_data [N];
  logic [31:0] m_mask [N];
  logic [RW-1:0] m_rsp [N];
  bit          m_en   [N];
  logic [15:0] mc1;
  logic [1:0]  mc2;

  always #5 clk = ~clk;

  fpu_ss_prd_table dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_instr_i(in_instr), .in_id_i(in_id),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_rsp_o(out_rsp),
    .out_hit_o(out_hit), .out_idx_o(out_idx), .out_id_o(out_id),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_entry_i(cfg_entry), .cfg_en_i(cfg_en),
    .miss_cnt_o(miss_cnt), .miss_clr_i(miss_clr)
  );

  fpu_ss_prd_table #(.MissCntW(2)) dut_sat (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(s_in_ready), .in_instr_i(in_instr), .in_id_i(in_id),
    .out_valid_o(s_out_valid), .out_ready_i(out_ready), .out_rsp_o(s_out_rsp),
    .out_hit_o(s_out_hit), .out_idx_o(s_out_idx), .out_id_o(s_out_id),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_entry_i(cfg_entry), .cfg_en_i(cfg_en),
    .miss_cnt_o(s_miss_cnt), .miss_clr_i(miss_clr)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int i = 0; i < int'(N); i++) begin
      m_data[i] = ZfinxTable[i].instr_data;
      m_mask[i] = ZfinxTable[i].instr_mask;
      m_rsp[i]  = ZfinxTable[i].prd_rsp;
      m_en[i]   = 1'b1;
    end
  endfunction

  function automatic void model_write(input logic [IdxW-1:0] idx, input logic [EW-1:0] e,
                                      input logic en);
    if (int'(idx) < int'(N)) begin
      m_data[idx] = e[EW-1 -: 32];
      m_mask[idx] = e[EW-33 -: 32];
      m_rsp[idx]  = e[RW-1:0];
      m_en[idx]   = en;
    end
  endfunction

  // First enabled entry whose masked bits equal its data; otherwise an all-zero miss.
  function automatic exp_t model_lookup(input logic [31:0] instr, input logic [3:0] id);
    exp_t r;
    bit   found;
    r     = '0;
    r.id  = id;
    found = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (!found && m_en[i] && ((instr & m_mask[i]) == m_data[i])) begin
        found = 1'b1;
        r.hit = 1'b1;
        r.idx = IdxW'(i);
        r.rsp = m_rsp[i];
      end
    end
    return r;
  endfunction

  function automatic exp_t mk(input bit hit, input int idx, input logic [RW-1:0] rsp,
                              input logic [3:0] id);
    exp_t r;
    r.hit = hit;
    r.idx = IdxW'(idx);
    r.rsp = rsp;
    r.id  = id;
    return r;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    bit   xmiss;
    forever begin
      @(negedge clk);
      if (rst) begin
        mc1 = '0;
        mc2 = '0;
        sb.delete();
      end else begin
        check("miss_cnt", 64'(miss_cnt), 64'(mc1));
        check("miss_cnt_sat", 64'(s_miss_cnt), 64'(mc2));
        xmiss = 1'b0;
        if (out_valid) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result: got id %0h, expected no result", out_id);
          end else begin
            // Held results are compared every cycle, so any drift while stalled shows up.
            e = sb[0];
            check("result_hit", 64'(out_hit), 64'(e.hit));
            check("result_idx", 64'(out_idx), 64'(e.idx));
            check("result_rsp", 64'(out_rsp), 64'(e.rsp));
            check("result_id", 64'(out_id), 64'(e.id));
            if (out_ready) begin
              void'(sb.pop_front());
              xmiss = !e.hit;
            end
          end
        end
        if (miss_clr) begin
          mc1 = '0;
          mc2 = '0;
        end else if (xmiss) begin
          if (mc1 != 16'hFFFF) mc1 = mc1 + 16'd1;
          if (mc2 != 2'b11) mc2 = mc2 + 2'd1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called just after a posedge; any cfg write or clear already driven lands on the first edge.
  task automatic issue(input logic [31:0] instr, input logic [3:0] id, input bit dir,
                       input exp_t dexp);
    bit done;
    int cyc;
    done     = 1'b0;
    cyc      = 0;
    in_valid = 1'b1;
    in_instr = instr;
    in_id    = id;
    while (!done && cyc < 50) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(dir ? dexp : model_lookup(instr, id));
        done = 1'b1;
      end
      if (cfg_we) model_write(cfg_idx, cfg_entry, cfg_en);
      @(posedge clk);
      #1;
      cfg_we   = 1'b0;
      miss_clr = 1'b0;
      cyc++;
    end
    in_valid = 1'b0;
    if (!done) fail_now("issue_accept");
  endtask

  task automatic cfg_write(input int idx, input logic [31:0] d, input logic [31:0] m,
                           input logic [RW-1:0] rsp, input logic en);
    cfg_we    = 1'b1;
    cfg_idx   = IdxW'(idx);
    cfg_entry = {d, m, rsp};
    cfg_en    = en;
    @(negedge clk);
    model_write(cfg_idx, cfg_entry, cfg_en);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (sb.size() != 0 && c < 100) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (sb.size() != 0) fail_now("drain");
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    int unsigned i;
    int unsigned r;
    i = $urandom_range(0, N - 1);
    r = $urandom_range(0, 9);
    if (r < 6) return ZfinxTable[i].instr_data | ($urandom & ~ZfinxTable[i].instr_mask);
    else if (r < 8) return $urandom;
    else return ($urandom & 32'hFFFF_FF80) | 32'h13;
  endfunction

  bit rand_done = 1'b0;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_rsp", 64'(out_rsp), 64'd0);
    check("reset_out_hit", 64'(out_hit), 64'd0);
    check("reset_out_idx", 64'(out_idx), 64'd0);
    check("reset_out_id", 64'(out_id), 64'd0);
    check("reset_miss_cnt", 64'(miss_cnt), 64'd0);
    rst = 1'b0;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Default hits and a miss
    issue(FADD, 4'h5, 1, mk(1, 4, RSP_FADD, 4'h5));
    issue(FMADD, 4'h6, 1, mk(1, 0, RSP_FMA, 4'h6));
    issue(ADDI, 4'h7, 1, mk(0, 0, '0, 4'h7));
    drain();
    check("miss_cnt_after_addi", 64'(miss_cnt), 64'd1);

    // Backpressure: second request must wait, results come out in order
    out_ready = 1'b0;
    issue(FADD, 4'hA, 1, mk(1, 4, RSP_FADD, 4'hA));
    fork
      issue(FMADD, 4'hB, 1, mk(1, 0, RSP_FMA, 4'hB));
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Disable entry 4 in the same cycle as a lookup that needs it
    cfg_we    = 1'b1;
    cfg_idx   = 5'd4;
    cfg_entry = {32'h0000_0053, MaskR, RSP_FADD};
    cfg_en    = 1'b0;
    issue(FADD, 4'h1, 1, mk(1, 4, RSP_FADD, 4'h1));
    issue(FADD, 4'h2, 1, mk(0, 0, '0, 4'h2));
    drain();
    check("miss_cnt_after_disable", 64'(miss_cnt), 64'd2);
    cfg_write(int'(N), 32'h0000_0053, MaskR, RSP_FADD, 1'b1);
    cfg_write(31, 32'h0000_0053, MaskR, RSP_FADD, 1'b1);
    issue(FADD, 4'h3, 1, mk(0, 0, '0, 4'h3));
    drain();

    // Priority: entry 2 reprogrammed as FADD without writeback beats entry 4
    cfg_write(2, 32'h0000_0053, MaskR, RSP_NOWB, 1'b1);
    issue(FADD, 4'h4, 1, mk(1, 2, RSP_NOWB, 4'h4));
    cfg_write(4, 32'h0000_0053, MaskR, RSP_FADD, 1'b1);
    issue(FADD, 4'h5, 1, mk(1, 2, RSP_NOWB, 4'h5));
    drain();

    // Saturation on the 2-bit counter, then clear racing a miss transfer
    miss_clr = 1'b1;
    @(posedge clk);
    #1;
    miss_clr = 1'b0;
    check("miss_cnt_cleared", 64'(miss_cnt), 64'd0);
    for (int k = 0; k < 5; k++) issue(ADDI, 4'(k), 1, mk(0, 0, '0, 4'(k)));
    drain();
    check("miss_cnt_five", 64'(miss_cnt), 64'd5);
    check("miss_cnt_saturated", 64'(s_miss_cnt), 64'd3);
    issue(ADDI, 4'hC, 1, mk(0, 0, '0, 4'hC));
    miss_clr = 1'b1;
    @(posedge clk);
    #1;
    miss_clr = 1'b0;
    check("clr_beats_inc", 64'(miss_cnt), 64'd0);
    check("clr_beats_inc_sat", 64'(s_miss_cnt), 64'd0);
    drain();

    // Randomized traffic with random backpressure, writes and clears
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          int unsigned j;
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          if ($urandom_range(0, 7) == 0) begin
            j         = $urandom_range(0, N - 1);
            cfg_we    = 1'b1;
            cfg_idx   = IdxW'($urandom_range(0, 31));
            cfg_entry = {ZfinxTable[j].instr_data, ZfinxTable[j].instr_mask, RW'($urandom)};
            cfg_en    = ($urandom_range(0, 3) != 0);
          end
          if ($urandom_range(0, 15) == 0) miss_clr = 1'b1;
          issue(rand_instr(), 4'($urandom), 0, '0);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Asynchronous reset while a result is stalled
    out_ready = 1'b0;
    issue(FADD, 4'hE, 0, '0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_valid", 64'(out_valid), 64'd0);
    check("async_reset_miss_cnt", 64'(miss_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    model_reset();
    issue(FADD, 4'h8, 1, mk(1, 4, RSP_FADD, 4'h8));
    issue(FNMSUB, 4'h9, 1, mk(1, 2, RSP_FMA, 4'h9));
    drain();
    check("queue_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
